// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver with a double-buffered display value,
// a programmable refresh prescaler, per-digit decimal points and leading-zero blanking.
module seven_seg_scan #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned CLK_DIV       = 50000,
    parameter bit          ACTIVE_LOW_AN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    input  logic                  enable,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{ACTIVE_LOW_AN}};

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   act_val_q, act_val_d, pend_val_q, pend_val_d;
    logic [DIGITS-1:0]     act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic                  pend_flag_q, pend_flag_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  fd_q, fd_d;

    logic                  tick, wrap;
    logic [3:0]            nib;
    logic                  cur_dp, lz_blank;
    logic [DIGITS-1:0]     an_sel;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        tick    = (presc_q == PW'(CLK_DIV - 1));
        wrap    = tick && (idx_q == IW'(DIGITS - 1));
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (tick) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        // Without a newer load, pending already equals active, so gating the copy is invisible.
        act_val_d   = act_val_q;
        act_dp_d    = act_dp_q;
        pend_flag_d = pend_flag_q;
        if (wrap) begin
            if (pend_flag_q) begin
                act_val_d = pend_val_q;
                act_dp_d  = pend_dp_q;
            end
            pend_flag_d = 1'b0;
        end
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        if (load) begin
            pend_val_d  = value;
            pend_dp_d   = dp_in;
            pend_flag_d = 1'b1;
        end
        fd_d = wrap;
    end

    always_comb begin
        nib      = '0;
        cur_dp   = 1'b0;
        lz_blank = 1'b0;
        an_sel   = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                nib       = act_val_q[4*k +: 4];
                cur_dp    = act_dp_q[k];
                an_sel[k] = 1'b1;
                lz_blank  = blank_lz && (k != 0) && ((act_val_q >> (4*k)) == '0);
            end
        end
        if (enable) begin
            seg_d = lz_blank ? 7'h7F : decode(nib);
            dp_d  = ~cur_dp;
            an_d  = an_sel ^ AN_OFF;
        end else begin
            seg_d = 7'h7F;
            dp_d  = 1'b1;
            an_d  = AN_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            idx_q       <= '0;
            act_val_q   <= '0;
            act_dp_q    <= '0;
            pend_val_q  <= '0;
            pend_dp_q   <= '0;
            pend_flag_q <= 1'b0;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
            an_q        <= AN_OFF;
            fd_q        <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            act_val_q   <= act_val_d;
            act_dp_q    <= act_dp_d;
            pend_val_q  <= pend_val_d;
            pend_dp_q   <= pend_dp_d;
            pend_flag_q <= pend_flag_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
            fd_q        <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment digits. It takes a packed hex value, double-buffers it so a digit never changes partway through a refresh frame, and scans the digits one at a time with a programmable refresh prescaler. Per-digit decimal points, optional leading-zero blanking and a global display enable are included. It sits between the game/score logic and the board display pins, and replaces per-digit static decoders.

## Interface

Parameters:
- DIGITS, 4: number of digits scanned (1..8).
- CLK_DIV, 50000: clock cycles each digit stays lit (≥1).
- ACTIVE_LOW_AN, 1: 1 means an bits are active-low; 0 means active-high.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle strobe that captures value and dp_in into the pending buffer.
- value  in  4*DIGITS  packed nibbles; nibble k = value[4k+3:4k] is digit k, and digit 0 is the least significant.
- dp_in  in  DIGITS  decimal point per digit; 1 = lit.
- blank_lz  in  1  1 enables leading-zero blanking.
- enable  in  1  0 blanks the entire display.
- seg  out  7  active-low segments, seg[6:0] = g,f,e,d,c,b,a.
- dp  out  1  active-low decimal point.
- an  out  DIGITS  digit select; one-hot, polarity set by ACTIVE_LOW_AN.
- frame_done  out  1  one-cycle pulse at each frame wrap.

## Operation

Refresh counter:
- The prescaler counts 0..CLK_DIV-1. tick is asserted when the count equals CLK_DIV-1; the counter then returns to 0.
- On tick, the digit index idx advances 0→1→…→DIGITS-1→0.

Frame wrap (a tick while idx = DIGITS-1):
- active ← pending (both value and dp).
- pend_flag is cleared.
- frame_done = 1 for that cycle.

Load behaviour:
- load = 1 sets pending ← {value, dp_in} and sets pend_flag.
- If load coincides with a frame wrap, active takes the old pending contents, and pending takes the new data with pend_flag left set. The new data appears one frame later.
- Back-to-back loads: the last one before a wrap wins.

Leading-zero blanking:
- Digit k is blanked when blank_lz = 1, k > 0, and every active nibble from k up to DIGITS-1 is 0.
- Digit 0 is never blanked.
- A blanked digit drives seg = 1111111, but its dp still follows active dp.
- The anode of a blanked digit is still driven.

Decode (nibble → seg):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110

Enable:
- enable = 0 forces all an bits inactive, seg = 1111111 and dp = 1.
- The prescaler, idx, buffers and frame_done keep running while disabled.

## Timing

Reset values (asserted asynchronously, released synchronously to clk):
- Prescaler = 0, idx = 0.
- active = 0, pending = 0, pend_flag = 0.
- seg = 1111111, dp = 1, frame_done = 0.
- an = all inactive: all 1s if ACTIVE_LOW_AN = 1, else all 0s.

Output registering:
- seg, dp and an are registered from (idx, active, enable, blank_lz), so they lag idx by one clock.
- an is exactly one-hot whenever enable = 1; there is never an overlap cycle.

Frame timing:
- Each digit is lit for CLK_DIV cycles, and one frame is DIGITS × CLK_DIV cycles.
- The first frame_done occurs DIGITS × CLK_DIV cycles after reset release.
- With CLK_DIV = 1, tick is asserted every cycle.

Load-to-display latency:
- A load is shown starting at the first digit-0 slot after the next frame wrap.
- The worst case is DIGITS × CLK_DIV + 1 cycles.

Reset mid-frame:
- Asserting rst_n low during a frame blanks the outputs immediately.
- Any pending data is lost.

## Test plan

1. Reset, DIGITS=4, CLK_DIV=3, enable=1 → on the first clock after release, an=1110, seg=1000000; an walks 1101, 1011, 0111 every 3 cycles; frame_done pulses at cycle 12.
2. load value=16'h12AF with dp_in=0100 mid-frame → the old digits continue to the end of the frame, then seg shows F(0001110), A(0001000), 2(0100100), 1(1111001) on digits 0..3, with dp=0 only on digit 2.
3. blank_lz=1, value=16'h0005 → digits 3, 2, 1 drive seg=1111111 with their anodes still selected; digit 0 shows 0010010. value=16'h0000 → only digit 0 lit, showing 1000000.
4. load asserted on the same cycle as a frame wrap, with a value already pending → the display shows the previously pending value for one frame, then the new value.
5. enable=0 mid-frame → the next clock gives an=1111, seg=1111111, dp=1, while frame_done still pulses every 12 cycles; re-enable → scanning resumes at the current idx.
6. rst_n pulsed low mid-digit, asynchronously between edges → outputs blank before the next clock edge; after release, the sequence matches scenario 1 with active=0.
